// File: rtl/leaf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | leaf_pkg : shared constants and width helpers for leaf_out_merge      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package leaf_pkg;

  localparam int PAYLOAD_BITS_DEFAULT = 32;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Channel-id field never collapses to zero width, even for one channel.
  function automatic int ch_id_bits(input int num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | leaf_sync_fifo : per-channel FIFO, 2^DEPTH_BITS words, sync flush     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module leaf_sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                   (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
  assign dout    = mem[rd_ptr[DEPTH_BITS-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_BITS-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/leaf_out_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | leaf_out_merge : round-robin merge of NUM_CH ap_vld/ap_ack channels   |
// | Optional LEAF_MERGE_STATS_EN adds per-channel push counters. Rev 1.0  |
// +----------------------------------------------------------------------+
module leaf_out_merge
  import leaf_pkg::*;
#(
  parameter  int NUM_CH          = 4,
  parameter  int PAYLOAD_BITS    = PAYLOAD_BITS_DEFAULT,
  parameter  int FIFO_DEPTH_BITS = 2,
  localparam int CH_BITS         = ch_id_bits(NUM_CH)
) (
  input  logic                           clk_user,
  input  logic                           reset,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_CH-1:0]              vld_user2interface,
  output logic [NUM_CH-1:0]              ack_interface2user,
  input  logic                           flush,
  output logic [CH_BITS+PAYLOAD_BITS-1:0] dout_merge,
  output logic                           dout_vld,
  input  logic                           dout_ack,
`ifdef LEAF_MERGE_STATS_EN
  output logic [NUM_CH*16-1:0]           pkt_cnt,
`endif
  output logic [NUM_CH-1:0]              fifo_full
);

  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_FULL  = 1'b1;

  logic [0:0]              state;
  logic [CH_BITS-1:0]      last_grant;
  logic [CH_BITS-1:0]      grant_ch;
  logic                    grant_found;
  logic                    load_en;
  logic [NUM_CH-1:0]       fifo_empty;
  logic [NUM_CH-1:0]       push;
  logic [NUM_CH-1:0]       pop;
  logic [PAYLOAD_BITS-1:0] fifo_dout [NUM_CH];

  assign ack_interface2user = vld_user2interface & ~fifo_full & {NUM_CH{~flush & ~reset}};
  assign push               = ack_interface2user;
  assign dout_vld           = (state == OUT_FULL);
  assign load_en            = ((state == OUT_EMPTY) || dout_ack) && grant_found && !flush;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_fifo
    leaf_sync_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk   (clk_user),
      .rst   (reset),
      .flush (flush),
      .push  (push[k]),
      .din   (din_leaf_user2interface[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .pop   (pop[k]),
      .dout  (fifo_dout[k]),
      .full  (fifo_full[k]),
      .empty (fifo_empty[k])
    );
  end

  // Round-robin search starting one past the previous winner.
  always_comb begin
    int                 idx_int;
    logic [CH_BITS-1:0] idx;
    grant_found = 1'b0;
    grant_ch    = '0;
    idx_int     = 0;
    idx         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_int = (int'(last_grant) + 1 + i) % NUM_CH;
      idx     = CH_BITS'(idx_int);
      if (!grant_found && !fifo_empty[idx]) begin
        grant_found = 1'b1;
        grant_ch    = idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pop[k] = load_en && (grant_ch == CH_BITS'(k));
    end
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      state      <= OUT_EMPTY;
      dout_merge <= '0;
      last_grant <= CH_BITS'(NUM_CH - 1);
    end else if (flush) begin
      state      <= OUT_EMPTY;
      dout_merge <= '0;
    end else if (load_en) begin
      state      <= OUT_FULL;
      dout_merge <= {grant_ch, fifo_dout[grant_ch]};
      last_grant <= grant_ch;
    end else if ((state == OUT_FULL) && dout_ack) begin
      state      <= OUT_EMPTY;
    end
  end

`ifdef LEAF_MERGE_STATS_EN
  // Counts accepted words; flush leaves history intact.
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) pkt_cnt[k*16 +: 16] <= pkt_cnt[k*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_leaf_out_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_leaf_out_merge : directed self-checking bench for leaf_out_merge   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_leaf_out_merge;

  localparam int NUM_CH = 4;
  localparam int PB     = 32;
  localparam int CHB    = 2;

  logic                   clk_user = 1'b0;
  logic                   reset    = 1'b1;
  logic                   flush    = 1'b0;
  logic                   dout_ack = 1'b0;
  logic [NUM_CH*PB-1:0]   din      = '0;
  logic [NUM_CH-1:0]      vld      = '0;
  logic [NUM_CH-1:0]      ack;
  logic [NUM_CH-1:0]      fifo_full;
  logic [CHB+PB-1:0]      dout_merge;
  logic                   dout_vld;
`ifdef LEAF_MERGE_STATS_EN
  logic [NUM_CH*16-1:0]   pkt_cnt;
`endif

  int tests = 0;
  int fails = 0;

  leaf_out_merge dut (
    .clk_user                (clk_user),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .flush                   (flush),
    .dout_merge              (dout_merge),
    .dout_vld                (dout_vld),
    .dout_ack                (dout_ack),
`ifdef LEAF_MERGE_STATS_EN
    .pkt_cnt                 (pkt_cnt),
`endif
    .fifo_full               (fifo_full)
  );

  always #5 clk_user = ~clk_user;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_user);
    #2;
  endtask

  task automatic set_din(input int ch, input logic [31:0] v);
    din[ch*PB +: PB] = v;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    vld   = '0;
    flush = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [CHB+PB-1:0] word(input int ch, input logic [31:0] p);
    return {CHB'(ch), p};
  endfunction

  initial begin
    int          got;
    int          emitted;
    logic        pushing;
    logic [31:0] p;

    // Reset state, with all channels requesting
    vld = 4'hF;
    #3;
    check("rst_vld",  dout_vld, 0);
    check("rst_data", dout_merge, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ack",  ack, 0);
    tick();
    reset = 1'b0;
    vld   = '0;
    tick();

    // Single word on ch2, two edges to dout_vld, one cycle wide
    dout_ack = 1'b1;
    set_din(2, 32'hDEADBEEF);
    vld = 4'b0100;
    #1;
    check("sw_ack", ack, 4'b0100);
    tick();
    vld = '0;
    check("sw_vld_t", dout_vld, 0);
    tick();
    check("sw_vld",  dout_vld, 1);
    check("sw_data", dout_merge, word(2, 32'hDEADBEEF));
    tick();
    check("sw_single", dout_vld, 0);

    // Fairness: all channels valid, continuous accept
    apply_reset();
    for (int k = 0; k < NUM_CH; k++) set_din(k, 32'hA0000000 | k);
    vld      = 4'hF;
    dout_ack = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rr_vld%0d", i),  dout_vld, 1);
      check($sformatf("rr_word%0d", i), dout_merge, word(i % 4, 32'hA0000000 | (i % 4)));
    end
    vld = '0;

    // Backpressure: W0 sits in the output register, W1..W4 fill the FIFO
    apply_reset();
    dout_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_din(0, 32'h10000000 + i);
      vld = 4'b0001;
      #1;
      if (i < 5) begin
        check($sformatf("bp_ack%0d", i), ack[0], 1);
        tick();
      end else begin
        check("bp_ack_full", ack[0], 0);
        check("bp_full", fifo_full[0], 1);
      end
    end
    tick();
    tick();
    check("bp_hold_vld",  dout_vld, 1);
    check("bp_hold_data", dout_merge, word(0, 32'h10000000));
    check("bp_hold_full", fifo_full[0], 1);
    dout_ack = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (dout_vld) begin
        p = 32'h10000000 + got;
        check($sformatf("bp_word%0d", got), dout_merge, word(0, p));
        got++;
      end
      pushing = vld[0] & ack[0];
      tick();
      if (pushing) vld = '0;
    end
    check("bp_count", got, 6);

    // Flush with one word in output and three buffered on ch1
    apply_reset();
    dout_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_din(1, 32'hF1000000 + i);
      vld = 4'b0010;
      tick();
    end
    vld = '0;
    check("fl_pre_vld",  dout_vld, 1);
    check("fl_pre_data", dout_merge, word(1, 32'hF1000000));
    flush    = 1'b1;
    dout_ack = 1'b1;
    vld      = 4'b0010;
    #1;
    check("fl_ack", ack, 0);
    tick();
    flush = 1'b0;
    vld   = '0;
    check("fl_vld",  dout_vld, 0);
    check("fl_full", fifo_full, 0);
    check("fl_data", dout_merge, 0);
    emitted = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dout_vld) emitted++;
    end
    check("fl_none", emitted, 0);
    // last_grant stays at ch1 across flush, so ch2 wins over ch0
    set_din(0, 32'h000000C0);
    set_din(2, 32'h000000C2);
    vld = 4'b0101;
    tick();
    vld = '0;
    tick();
    check("fl_rr_first",  dout_merge, word(2, 32'h000000C2));
    tick();
    check("fl_rr_second", dout_merge, word(0, 32'h000000C0));

    // Asynchronous reset in the middle of a burst
    apply_reset();
    for (int k = 0; k < NUM_CH; k++) set_din(k, 32'hB0 + k);
    vld      = 4'hF;
    dout_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("ar_pre_vld",  dout_vld, 1);
    check("ar_pre_full", fifo_full, 4'b1000);
    check("ar_pre_data", dout_merge, word(2, 32'hB2));
    #2;
    reset = 1'b1;
    #1;
    check("ar_vld",  dout_vld, 0);
    check("ar_ack",  ack, 0);
    check("ar_full", fifo_full, 0);
    check("ar_data", dout_merge, 0);
    vld = '0;
    tick();
    tick();
    reset = 1'b0;
    vld   = 4'b1001;
    tick();
    vld = '0;
    tick();
    check("ar_first",  dout_merge, word(0, 32'hB0));
    tick();
    check("ar_second", dout_merge, word(3, 32'hB3));
    tick();
    check("ar_drained", dout_vld, 0);

`ifdef LEAF_MERGE_STATS_EN
    // 65537 pushes on ch3 wrap its counter to 1
    apply_reset();
    dout_ack = 1'b1;
    set_din(3, 32'h33333333);
    vld = 4'b1000;
    for (int i = 0; i < 65537; i++) tick();
    vld = '0;
    tick();
    check("st_cnt3", pkt_cnt[3*16 +: 16], 16'd1);
    check("st_cnt0", pkt_cnt[0*16 +: 16], 16'd0);
    check("st_cnt1", pkt_cnt[1*16 +: 16], 16'd0);
    check("st_cnt2", pkt_cnt[2*16 +: 16], 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
